// File: rtl/vram_reader.sv
// AXI4 read master: streams one display frame per accepted VSTART from VRAM
// into the pixel FIFO using fixed-length INCR bursts, one burst in flight.
module vram_reader #(
  parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
  parameter int C_M_AXI_ADDR_WIDTH      = 32,
  parameter int C_M_AXI_DATA_WIDTH      = 64,
  parameter int C_M_AXI_ARUSER_WIDTH    = 1,
  parameter int C_BURST_LEN             = 16,
  parameter int C_FRAME_BEATS           = 153600
) (
  input  logic                               ACLK,
  input  logic                               ARST,
  input  logic                               DISPON,
  input  logic                               VSTART,
  input  logic [31:0]                        BASEADDR,
  output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR,
  output logic [7:0]                         M_AXI_ARLEN,
  output logic [2:0]                         M_AXI_ARSIZE,
  output logic [1:0]                         M_AXI_ARBURST,
  output logic [1:0]                         M_AXI_ARLOCK,
  output logic [3:0]                         M_AXI_ARCACHE,
  output logic [2:0]                         M_AXI_ARPROT,
  output logic [3:0]                         M_AXI_ARQOS,
  output logic [C_M_AXI_ARUSER_WIDTH-1:0]    M_AXI_ARUSER,
  output logic                               M_AXI_ARVALID,
  input  logic                               M_AXI_ARREADY,
  input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_RDATA,
  input  logic [1:0]                         M_AXI_RRESP,
  input  logic                               M_AXI_RLAST,
  input  logic                               M_AXI_RVALID,
  output logic                               M_AXI_RREADY,
  output logic                               FIFO_WR,
  output logic [C_M_AXI_DATA_WIDTH-1:0]      FIFO_WDATA,
  input  logic                               FIFO_AFULL,
  output logic                               RD_BUSY,
  output logic                               RD_ERR
);

  localparam int BEAT_W = $clog2(C_FRAME_BEATS + 1);
  localparam int BCNT_W = 9;
  localparam logic [28:0] ADDR_INC = 29'(C_BURST_LEN * 8);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ADDR, S_DATA} state_t;

  state_t              state_q, state_d;
  logic [28:0]         addr_q, addr_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [BCNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic                rd_busy_q, rd_busy_d;
  logic                rd_err_q, rd_err_d;
  logic                abort_q, abort_d;

  logic beat, burst_last, frame_last, overrun;
  logic unused_ok;

  assign unused_ok = ^{M_AXI_RID, BASEADDR[31:29]};

  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = {3'b001, addr_q};
  assign M_AXI_ARLEN   = 8'(C_BURST_LEN - 1);
  assign M_AXI_ARSIZE  = 3'b011;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARLOCK  = 2'b00;
  assign M_AXI_ARCACHE = 4'b0011;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARQOS   = 4'b0000;
  assign M_AXI_ARUSER  = '0;
  assign M_AXI_ARVALID = (state_q == S_ADDR);
  assign M_AXI_RREADY  = (state_q == S_DATA);
  assign FIFO_WR       = M_AXI_RVALID && M_AXI_RREADY;
  assign FIFO_WDATA    = M_AXI_RDATA;
  assign RD_BUSY       = rd_busy_q;
  assign RD_ERR        = rd_err_q;

  assign beat       = FIFO_WR;
  assign burst_last = (burst_cnt_q == BCNT_W'(C_BURST_LEN - 1));
  assign frame_last = (beat_cnt_q == BEAT_W'(C_FRAME_BEATS - 1));
  assign overrun    = VSTART && rd_busy_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    beat_cnt_d  = beat_cnt_q;
    burst_cnt_d = burst_cnt_q;
    rd_busy_d   = rd_busy_q;
    rd_err_d    = rd_err_q;
    abort_d     = abort_q;

    // A VSTART during a frame is never accepted; it only flags and aborts.
    if (overrun) begin
      rd_err_d = 1'b1;
      abort_d  = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (VSTART && DISPON) begin
          addr_d     = BASEADDR[28:0];
          beat_cnt_d = '0;
          rd_busy_d  = 1'b1;
          abort_d    = 1'b0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        // No burst is in flight here, so an abort can take effect at once.
        if (!DISPON || abort_q || overrun) begin
          rd_busy_d = 1'b0;
          abort_d   = 1'b0;
          state_d   = S_IDLE;
        end else if (!FIFO_AFULL) begin
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (M_AXI_ARREADY) begin
          burst_cnt_d = '0;
          state_d     = S_DATA;
        end
      end
      S_DATA: begin
        if (beat) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
          beat_cnt_d  = beat_cnt_q + 1'b1;
          if (M_AXI_RRESP != 2'b00 || M_AXI_RLAST != burst_last) begin
            rd_err_d = 1'b1;
          end
          // The local beat count, not RLAST, decides where a burst ends.
          if (burst_last) begin
            addr_d = addr_q + ADDR_INC;
            if (frame_last || abort_q || overrun) begin
              rd_busy_d = 1'b0;
              abort_d   = 1'b0;
              state_d   = S_IDLE;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      beat_cnt_q  <= '0;
      burst_cnt_q <= '0;
      rd_busy_q   <= 1'b0;
      rd_err_q    <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      rd_busy_q   <= rd_busy_d;
      rd_err_q    <= rd_err_d;
      abort_q     <= abort_d;
    end
  end

endmodule
